// File: rtl/pc_fetch_ctrl_pkg.sv
// Shared NPC opcode and fetch-state encodings for the MIPS fetch path.
package pc_fetch_ctrl_pkg;

    localparam logic [1:0] NPC_PLUS4  = 2'b00;
    localparam logic [1:0] NPC_BRANCH = 2'b01;
    localparam logic [1:0] NPC_JUMP   = 2'b10;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        REQ  = 2'd1,
        HOLD = 2'd2
    } state_e;

endpackage

// File: rtl/pc_fetch_ctrl_npc_target.sv
// Redirect target computation: PC+4, PC-relative branch, or region jump.
module npc_target
    import pc_fetch_ctrl_pkg::*;
(
    input  logic [31:0] redir_pc,
    input  logic [1:0]  redir_op,
    input  logic [25:0] redir_imm,
    output logic [31:0] target
);

    logic [31:0] p4;
    logic [31:0] br_off;

    always_comb begin
        p4     = redir_pc + 32'd4;
        br_off = {{14{redir_imm[15]}}, redir_imm[15:0], 2'b00};
        target = p4;
        case (redir_op)
            NPC_BRANCH: target = p4 + br_off;
            NPC_JUMP:   target = {p4[31:28], redir_imm, 2'b00};
            default:    target = p4;
        endcase
    end

endmodule

// File: rtl/pc_fetch_ctrl.sv
// Fetch sequencer: owns the PC, drives imem req/ack, hands words to decode.
module pc_fetch_ctrl
    import pc_fetch_ctrl_pkg::*;
#(
    parameter logic [31:0] RESET_PC = 32'h0000_3000
) (
    input  logic        clk,
    input  logic        rstn,
    output logic        imem_req,
    output logic [31:0] imem_addr,
    input  logic        imem_ack,
    input  logic [31:0] imem_rdata,
    output logic        inst_valid,
    output logic [31:0] inst,
    output logic [31:0] inst_pc,
    input  logic        inst_ready,
    input  logic        redir_valid,
    input  logic [1:0]  redir_op,
    input  logic [25:0] redir_imm,
    input  logic [31:0] redir_pc
);

    state_e      state_q, state_d;
    logic [31:0] pc_q, pc_d;
    logic [31:0] inst_q, inst_d;
    logic [31:0] inst_pc_q, inst_pc_d;
    logic        pend_valid_q, pend_valid_d;
    logic [31:0] pend_pc_q, pend_pc_d;
    logic [31:0] target;

    npc_target u_npc (
        .redir_pc  (redir_pc),
        .redir_op  (redir_op),
        .redir_imm (redir_imm),
        .target    (target)
    );

    always_ff @(posedge clk) begin
        if (!rstn) state_q <= IDLE;
        else       state_q <= state_d;
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE: state_d = REQ;
            REQ: begin
                if (imem_ack && !pend_valid_q && !redir_valid)
                    state_d = HOLD;
            end
            HOLD: begin
                if (inst_ready || redir_valid)
                    state_d = REQ;
            end
            default: state_d = IDLE;
        endcase
    end

    always_comb begin
        pc_d         = pc_q;
        inst_d       = inst_q;
        inst_pc_d    = inst_pc_q;
        pend_valid_d = pend_valid_q;
        pend_pc_d    = pend_pc_q;
        case (state_q)
            IDLE: begin
                if (redir_valid) pc_d = target;
            end
            REQ: begin
                if (imem_ack) begin
                    // A redirect seen during this request makes rdata stale.
                    if (redir_valid)       pc_d = target;
                    else if (pend_valid_q) pc_d = pend_pc_q;
                    else begin
                        inst_d    = imem_rdata;
                        inst_pc_d = pc_q;
                        pc_d      = pc_q + 32'd4;
                    end
                    pend_valid_d = 1'b0;
                end else if (redir_valid) begin
                    pend_valid_d = 1'b1;
                    pend_pc_d    = target;
                end
            end
            HOLD: begin
                if (redir_valid) pc_d = target;
            end
            default: ;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rstn) begin
            pc_q         <= RESET_PC;
            inst_q       <= 32'd0;
            inst_pc_q    <= 32'd0;
            pend_valid_q <= 1'b0;
            pend_pc_q    <= 32'd0;
        end else begin
            pc_q         <= pc_d;
            inst_q       <= inst_d;
            inst_pc_q    <= inst_pc_d;
            pend_valid_q <= pend_valid_d;
            pend_pc_q    <= pend_pc_d;
        end
    end

    always_comb begin
        imem_req   = (state_q == REQ);
        inst_valid = (state_q == HOLD);
        imem_addr  = pc_q;
        inst       = inst_q;
        inst_pc    = inst_pc_q;
    end

endmodule

// File: tb/tb_pc_fetch_ctrl.sv
// Directed scenario bench for the fetch sequencer.
module tb_pc_fetch_ctrl;

    logic        clk = 1'b0;
    logic        rstn;
    logic        imem_req;
    logic [31:0] imem_addr;
    logic        imem_ack;
    logic [31:0] imem_rdata;
    logic        inst_valid;
    logic [31:0] inst;
    logic [31:0] inst_pc;
    logic        inst_ready;
    logic        redir_valid;
    logic [1:0]  redir_op;
    logic [25:0] redir_imm;
    logic [31:0] redir_pc;

    int npass = 0;
    int ntotal = 0;

    pc_fetch_ctrl dut (
        .clk         (clk),
        .rstn        (rstn),
        .imem_req    (imem_req),
        .imem_addr   (imem_addr),
        .imem_ack    (imem_ack),
        .imem_rdata  (imem_rdata),
        .inst_valid  (inst_valid),
        .inst        (inst),
        .inst_pc     (inst_pc),
        .inst_ready  (inst_ready),
        .redir_valid (redir_valid),
        .redir_op    (redir_op),
        .redir_imm   (redir_imm),
        .redir_pc    (redir_pc)
    );

    always #5 clk = ~clk;

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic redir(input logic [1:0] op, input logic [25:0] imm, input logic [31:0] rpc);
        redir_valid = 1'b1;
        redir_op    = op;
        redir_imm   = imm;
        redir_pc    = rpc;
    endtask

    task automatic test_reset();
        rstn = 1'b0;
        imem_ack = 1'b1;
        imem_rdata = 32'hDEAD_BEEF;
        inst_ready = 1'b1;
        redir(2'b10, 26'h0000400, 32'h0000_3010);
        step();
        step();
        ntotal++; if (imem_req !== 1'b0) $display("FAIL rst_req got %b exp 0", imem_req); else npass++;
        ntotal++; if (imem_addr !== 32'h3000) $display("FAIL rst_addr got %h exp 00003000", imem_addr); else npass++;
        ntotal++; if (inst_valid !== 1'b0) $display("FAIL rst_valid got %b exp 0", inst_valid); else npass++;
        ntotal++; if (inst !== 32'h0) $display("FAIL rst_inst got %h exp 0", inst); else npass++;
        ntotal++; if (inst_pc !== 32'h0) $display("FAIL rst_inst_pc got %h exp 0", inst_pc); else npass++;
        imem_ack = 1'b0;
        imem_rdata = 32'h0;
        inst_ready = 1'b0;
        redir_valid = 1'b0;
    endtask

    task automatic test_zero_wait();
        rstn = 1'b1;
        step();
        for (int i = 0; i < 3; i++) begin
            logic [31:0] a;
            logic [31:0] w;
            a = 32'h3000 + 32'(4 * i);
            w = 32'hA000_0000 + 32'(i);
            ntotal++; if (imem_req !== 1'b1) $display("FAIL zw_req[%0d] got %b exp 1", i, imem_req); else npass++;
            ntotal++; if (imem_addr !== a) $display("FAIL zw_addr[%0d] got %h exp %h", i, imem_addr, a); else npass++;
            imem_ack = 1'b1;
            imem_rdata = w;
            step();
            imem_ack = 1'b0;
            ntotal++; if (inst_valid !== 1'b1) $display("FAIL zw_valid[%0d] got %b exp 1", i, inst_valid); else npass++;
            ntotal++; if (inst !== w) $display("FAIL zw_inst[%0d] got %h exp %h", i, inst, w); else npass++;
            ntotal++; if (inst_pc !== a) $display("FAIL zw_inst_pc[%0d] got %h exp %h", i, inst_pc, a); else npass++;
            ntotal++; if (imem_req !== 1'b0) $display("FAIL zw_req_hold[%0d] got %b exp 0", i, imem_req); else npass++;
            inst_ready = 1'b1;
            step();
            inst_ready = 1'b0;
        end
        ntotal++; if (imem_addr !== 32'h300C) $display("FAIL zw_addr_end got %h exp 0000300c", imem_addr); else npass++;
    endtask

    task automatic test_stall();
        rstn = 1'b0;
        step();
        rstn = 1'b1;
        step();
        imem_ack = 1'b1;
        imem_rdata = 32'h1111_0000;
        step();
        imem_ack = 1'b0;
        // decode stalls one cycle: word must stay presented
        step();
        ntotal++; if (inst_valid !== 1'b1) $display("FAIL st_hold_valid got %b exp 1", inst_valid); else npass++;
        ntotal++; if (inst !== 32'h1111_0000) $display("FAIL st_hold_inst got %h exp 11110000", inst); else npass++;
        inst_ready = 1'b1;
        step();
        inst_ready = 1'b0;
        for (int k = 0; k < 4; k++) begin
            ntotal++; if (imem_req !== 1'b1) $display("FAIL st_req[%0d] got %b exp 1", k, imem_req); else npass++;
            ntotal++; if (imem_addr !== 32'h3004) $display("FAIL st_addr[%0d] got %h exp 00003004", k, imem_addr); else npass++;
            ntotal++; if (inst_valid !== 1'b0) $display("FAIL st_valid[%0d] got %b exp 0", k, inst_valid); else npass++;
            if (k == 3) begin
                imem_ack = 1'b1;
                imem_rdata = 32'hB000_0004;
            end
            step();
        end
        imem_ack = 1'b0;
        ntotal++; if (inst_valid !== 1'b1) $display("FAIL st_valid_ack got %b exp 1", inst_valid); else npass++;
        ntotal++; if (inst !== 32'hB000_0004) $display("FAIL st_inst got %h exp b0000004", inst); else npass++;
        ntotal++; if (inst_pc !== 32'h3004) $display("FAIL st_inst_pc got %h exp 00003004", inst_pc); else npass++;
        inst_ready = 1'b1;
        step();
        inst_ready = 1'b0;
        imem_ack = 1'b1;
        imem_rdata = 32'hC000_0008;
        step();
        imem_ack = 1'b0;
        ntotal++; if (inst_pc !== 32'h3008) $display("FAIL st_inst_pc2 got %h exp 00003008", inst_pc); else npass++;
    endtask

    task automatic test_branch();
        inst_ready = 1'b1;
        redir(2'b01, 26'h000FFFE, 32'h0000_3008);
        step();
        inst_ready = 1'b0;
        redir_valid = 1'b0;
        ntotal++; if (imem_req !== 1'b1) $display("FAIL br_req got %b exp 1", imem_req); else npass++;
        ntotal++; if (imem_addr !== 32'h3004) $display("FAIL br_addr got %h exp 00003004", imem_addr); else npass++;
        ntotal++; if (inst_valid !== 1'b0) $display("FAIL br_valid got %b exp 0", inst_valid); else npass++;
    endtask

    task automatic test_redir_stall();
        step();
        redir(2'b10, 26'h0000400, 32'h0000_3010);
        step();
        redir_valid = 1'b0;
        ntotal++; if (imem_addr !== 32'h3004) $display("FAIL rs_addr_held got %h exp 00003004", imem_addr); else npass++;
        imem_ack = 1'b1;
        imem_rdata = 32'hDDDD_DDDD;
        step();
        imem_ack = 1'b0;
        ntotal++; if (inst_valid !== 1'b0) $display("FAIL rs_drop got %b exp 0", inst_valid); else npass++;
        ntotal++; if (imem_addr !== 32'h1000) $display("FAIL rs_addr got %h exp 00001000", imem_addr); else npass++;
        imem_ack = 1'b1;
        imem_rdata = 32'hEEEE_0001;
        step();
        imem_ack = 1'b0;
        ntotal++; if (inst_pc !== 32'h1000) $display("FAIL rs_inst_pc got %h exp 00001000", inst_pc); else npass++;
        ntotal++; if (inst !== 32'hEEEE_0001) $display("FAIL rs_inst got %h exp eeee0001", inst); else npass++;
        inst_ready = 1'b1;
        step();
        inst_ready = 1'b0;
    endtask

    task automatic test_double_redir();
        redir(2'b10, 26'h0000C40, 32'h0000_1004);
        step();
        redir(2'b10, 26'h0000C80, 32'h0000_1004);
        step();
        redir_valid = 1'b0;
        ntotal++; if (imem_addr !== 32'h1004) $display("FAIL dr_addr_held got %h exp 00001004", imem_addr); else npass++;
        imem_ack = 1'b1;
        step();
        imem_ack = 1'b0;
        ntotal++; if (inst_valid !== 1'b0) $display("FAIL dr_drop got %b exp 0", inst_valid); else npass++;
        ntotal++; if (imem_addr !== 32'h3200) $display("FAIL dr_addr got %h exp 00003200", imem_addr); else npass++;
        imem_ack = 1'b1;
        imem_rdata = 32'hF000_3200;
        step();
        imem_ack = 1'b0;
        ntotal++; if (inst_pc !== 32'h3200) $display("FAIL dr_inst_pc got %h exp 00003200", inst_pc); else npass++;
        inst_ready = 1'b1;
        step();
        inst_ready = 1'b0;
    endtask

    task automatic test_wrap();
        // redirect coincident with ack
        redir(2'b10, 26'h3FF_FFFF, 32'hF000_0000);
        imem_ack = 1'b1;
        step();
        redir_valid = 1'b0;
        ntotal++; if (inst_valid !== 1'b0) $display("FAIL wr_drop got %b exp 0", inst_valid); else npass++;
        ntotal++; if (imem_addr !== 32'hFFFF_FFFC) $display("FAIL wr_addr_top got %h exp fffffffc", imem_addr); else npass++;
        imem_rdata = 32'h6666_6666;
        step();
        imem_ack = 1'b0;
        ntotal++; if (inst_pc !== 32'hFFFF_FFFC) $display("FAIL wr_inst_pc got %h exp fffffffc", inst_pc); else npass++;
        inst_ready = 1'b1;
        step();
        inst_ready = 1'b0;
        ntotal++; if (imem_addr !== 32'h0) $display("FAIL wr_addr got %h exp 00000000", imem_addr); else npass++;
    endtask

    task automatic test_reset_mid();
        rstn = 1'b0;
        step();
        ntotal++; if (imem_req !== 1'b0) $display("FAIL rm_req got %b exp 0", imem_req); else npass++;
        ntotal++; if (imem_addr !== 32'h3000) $display("FAIL rm_addr got %h exp 00003000", imem_addr); else npass++;
        ntotal++; if (inst_pc !== 32'h0) $display("FAIL rm_inst_pc got %h exp 0", inst_pc); else npass++;
        rstn = 1'b1;
        imem_ack = 1'b1;
        imem_rdata = 32'h7777_7777;
        step();
        imem_ack = 1'b0;
        ntotal++; if (imem_req !== 1'b1) $display("FAIL rm_late_req got %b exp 1", imem_req); else npass++;
        ntotal++; if (inst_valid !== 1'b0) $display("FAIL rm_late_valid got %b exp 0", inst_valid); else npass++;
        ntotal++; if (imem_addr !== 32'h3000) $display("FAIL rm_late_addr got %h exp 00003000", imem_addr); else npass++;
    endtask

    task automatic test_flush();
        imem_ack = 1'b1;
        imem_rdata = 32'h8888_8888;
        step();
        imem_ack = 1'b0;
        redir(2'b11, 26'h0, 32'h0000_5000);
        step();
        redir_valid = 1'b0;
        ntotal++; if (inst_valid !== 1'b0) $display("FAIL fl_valid got %b exp 0", inst_valid); else npass++;
        ntotal++; if (imem_addr !== 32'h5004) $display("FAIL fl_addr got %h exp 00005004", imem_addr); else npass++;
        ntotal++; if (inst !== 32'h8888_8888) $display("FAIL fl_inst_kept got %h exp 88888888", inst); else npass++;
    endtask

    initial begin
        rstn = 1'b0;
        imem_ack = 1'b0;
        imem_rdata = 32'h0;
        inst_ready = 1'b0;
        redir_valid = 1'b0;
        redir_op = 2'b00;
        redir_imm = 26'h0;
        redir_pc = 32'h0;
        test_reset();
        test_zero_wait();
        test_stall();
        test_branch();
        test_redir_stall();
        test_double_redir();
        test_wrap();
        test_reset_mid();
        test_flush();
        $display("%0d/%0d checks passed", npass, ntotal);
        $finish;
    end

endmodule
